aes128_key_expand: RTL and testbench

Iterative AES-128 key schedule that expands a 128-bit cipher key into the 11 round keys (44 words) consumed by the round datapath. It computes one schedule word per clock, reusing the existing 4-byte `Sbox` block for SubWord. Each round key is streamed out as soon as it completes and is also held in an internal 11-entry store for random-access reads by the round controller.

---
 rtl/aes_pkg.sv | 14 +
 rtl/Sbox.sv | 39 +++
 rtl/aes128_key_expand.sv | 101 ++++++++++
 tb/tb_aes128_key_expand.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule.
package aes_pkg;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int NUM_ROUNDS = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {IDLE, EXPAND} state_t;
endpackage

// File: rtl/Sbox.sv
// Four parallel AES S-boxes; byte 3 of the word is the MSB byte.
module Sbox
    import aes_pkg::*;
(
    input  word_t in_word,
    output word_t out_word
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = a;
        p = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
                 ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        out_word = '0;
        for (int b = 0; b < 4; b++)
            out_word[8*b +: 8] = sbox_byte(in_word[8*b +: 8]);
    end
endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one word per clock, round keys streamed
// out as they complete and kept in an 11-entry read store.
module aes128_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);
    state_t state, state_next;
    logic [5:0] idx;
    word_t  win [4];          // w[i-4] .. w[i-1]
    block_t store [0:NUM_ROUNDS];
    word_t  rot, sub, temp, new_w;
    logic   accept, round_end, last_word;

    assign rot = {win[3][23:0], win[3][31:24]};

    Sbox u_sbox (
        .in_word  (rot),
        .out_word (sub)
    );

    always_comb begin
        temp = win[3];
        if (idx[1:0] == 2'd0 && state == EXPAND)
            temp = sub ^ {RCON[idx[5:2]], 24'h0};
        new_w = win[0] ^ temp;
    end

    assign accept    = (state == IDLE) && start;
    assign round_end = (state == EXPAND) && (idx[1:0] == 2'd3);
    assign last_word = (state == EXPAND) && (idx == 6'd43);
    assign busy      = (state == EXPAND);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXPAND;
            EXPAND:  if (last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            done      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_round  <= '0;
            round_key <= '0;
            for (int k = 0; k < 4; k++) win[k] <= '0;
            for (int k = 0; k <= NUM_ROUNDS; k++) store[k] <= '0;
        end else begin
            rk_valid <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                win[0]    <= key_in[127:96];
                win[1]    <= key_in[95:64];
                win[2]    <= key_in[63:32];
                win[3]    <= key_in[31:0];
                store[0]  <= key_in;
                round_key <= key_in;
                rk_round  <= 4'd0;
                rk_valid  <= 1'b1;
                idx       <= 6'd4;
            end else if (state == EXPAND) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= win[3];
                win[3] <= new_w;
                idx    <= idx + 6'd1;
                if (round_end) begin
                    store[idx[5:2]] <= {win[1], win[2], win[3], new_w};
                    round_key       <= {win[1], win[2], win[3], new_w};
                    rk_round        <= idx[5:2];
                    rk_valid        <= 1'b1;
                end
                if (last_word) done <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_round <= 4'(NUM_ROUNDS)) rd_key = store[rd_round];
    end
endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand with a round-key scoreboard.
module tb_aes128_key_expand;
    logic         clk = 1'b0;
    logic         reset, start;
    logic [127:0] key_in;
    logic         busy, done, rk_valid;
    logic [3:0]   rk_round, rd_round;
    logic [127:0] round_key, rd_key;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;
    exp_t sb [$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_r1, zero_r10;

    aes128_key_expand dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .rk_valid(rk_valid), .rk_round(rk_round),
        .round_key(round_key), .rd_round(rd_round), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input bit zero);
        exp_t e;
        for (int r = 0; r <= 10; r++) begin
            e.round = 4'(r);
            if (zero) begin
                e.chk_key = (r == 0 || r == 1 || r == 10);
                e.key = (r == 0) ? 128'h0 : (r == 1) ? zero_r1 : zero_r10;
            end else begin
                e.chk_key = 1'b1;
                e.key = fips_rk[r];
            end
            sb.push_back(e);
        end
    endtask

    // Pulse monitor: pops the scoreboard and checks 4-cycle spacing.
    int cyc = 0;
    int last_pulse = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (rk_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rk_valid", {124'h0, rk_round}, 128'hffff);
            end else begin
                e = sb.pop_front();
                check("rk_round", {124'h0, rk_round}, {124'h0, e.round});
                if (e.chk_key) check($sformatf("round_key_r%0d", e.round), round_key, e.key);
                if (e.round != 0)
                    check("pulse_spacing", 128'(cyc - last_pulse), 128'd4);
            end
            last_pulse = cyc;
        end
    end

    task automatic do_start(input logic [127:0] k, input bit zero);
        push_run(zero);
        start = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done after an accept; optionally pokes start mid-run.
    task automatic wait_done(input string tag, input int ign1, input int ign2);
        int lat;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            if (n == ign1 || n == ign2) begin
                start = 1'b1;
                key_in = 128'h00112233445566778899aabbccddeeff;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_done_latency"}, 128'(lat), 128'd40);
        check({tag, "_busy_after_done"}, {127'h0, busy}, 128'h0);
    endtask

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_r1  = 128'h62636363626363636263636362636363;
        zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        reset = 1'b1; start = 1'b0; key_in = '0; rd_round = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", {127'h0, busy}, 128'h0);
        check("reset_done", {127'h0, done}, 128'h0);
        check("reset_rk_valid", {127'h0, rk_valid}, 128'h0);
        check("reset_round_key", round_key, 128'h0);
        check("reset_rd_key", rd_key, 128'h0);

        // FIPS key, plain run
        @(posedge clk); #1;
        do_start(FIPS_KEY, 1'b0);
        check("busy_after_accept", {127'h0, busy}, 128'h1);
        wait_done("fips", 0, 0);
        for (int r = 0; r <= 10; r++) begin
            rd_round = 4'(r); #1;
            check($sformatf("readback_r%0d", r), rd_key, fips_rk[r]);
        end
        rd_round = 4'd15; #1;
        check("readback_r15", rd_key, 128'h0);

        // All-zero key
        @(posedge clk); #1;
        do_start(128'h0, 1'b1);
        wait_done("zero", 0, 0);
        rd_round = 4'd1; #1;
        check("zero_store1", rd_key, zero_r1);

        // Start pulses while busy must be ignored
        @(posedge clk); #1;
        do_start(FIPS_KEY, 1'b0);
        wait_done("ignore", 5, 20);
        rd_round = 4'd10; #1;
        check("ignore_store10", rd_key, fips_rk[10]);

        // Reset at T+17: rounds 0..4 already reported
        @(posedge clk); #1;
        start = 1'b1; key_in = FIPS_KEY;
        for (int r = 0; r <= 4; r++) begin
            exp_t e;
            e.round = 4'(r); e.key = fips_rk[r]; e.chk_key = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_busy", {127'h0, busy}, 128'h0);
        check("midreset_rk_valid", {127'h0, rk_valid}, 128'h0);
        check("midreset_sb_drained", 128'(sb.size()), 128'd0);
        repeat (8) @(posedge clk);
        #1;
        for (int r = 0; r <= 10; r++) begin
            rd_round = 4'(r); #1;
            check($sformatf("midreset_store_r%0d", r), rd_key, 128'h0);
        end
        do_start(FIPS_KEY, 1'b0);
        wait_done("after_reset", 0, 0);

        // Back-to-back: zero key accepted in the done cycle
        do_start(128'h0, 1'b1);
        wait_done("b2b", 0, 0);
        rd_round = 4'd10; #1;
        check("b2b_store10", rd_key, zero_r10);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
